// File: rtl/dmem_access_ctrl_if.sv
// Data-memory request/ready bus between the MEM-stage access controller
// (master) and a variable-latency data memory (slave).
interface dmem_access_ctrl_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_ready,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_ready,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory access sequencer: IDLE -> BUSY -> DONE handshake with
// a variable-latency memory, pipeline stall generation and a sticky timeout.
module dmem_access_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 MemRead_MEM,
    input  logic                 MemWrite_MEM,
    input  logic [31:0]          ALUresult_MEM,
    input  logic [31:0]          data2_MEM,
    dmem_access_ctrl_if.master   mem,
    output logic [31:0]          rdata_out,
    output logic                 stall,
    output logic                 timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_mem_req;
    logic               r_mem_we;
    logic [31:0]        r_mem_addr;
    logic [31:0]        r_mem_wdata;
    logic [31:0]        r_rdata_out;
    logic               r_timeout_err;

    logic               w_access;
    logic               w_stall;

    assign w_access = MemRead_MEM | MemWrite_MEM;

    // Access sequencer: latches the request, waits for ready or timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_mem_req     <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_rdata_out   <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_access) begin
                        r_mem_addr  <= ALUresult_MEM;
                        r_mem_wdata <= data2_MEM;
                        r_mem_we    <= MemWrite_MEM;
                        r_mem_req   <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    // Ready on the timeout edge still counts as success.
                    if (mem.mem_ready) begin
                        r_mem_req <= 1'b0;
                        if (!r_mem_we) begin
                            r_rdata_out <= mem.mem_rdata;
                        end
                        r_state <= S_DONE;
                    end else if (r_cnt == LP_CNT_LAST) begin
                        r_mem_req     <= 1'b0;
                        r_timeout_err <= 1'b1;
                        if (!r_mem_we) begin
                            r_rdata_out <= '0;
                        end
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Pipeline freeze: pending access in IDLE, whole of BUSY; released in DONE.
    always_comb begin
        w_stall = 1'b0;
        case (r_state)
            S_IDLE:  w_stall = w_access;
            S_BUSY:  w_stall = 1'b1;
            default: w_stall = 1'b0;
        endcase
        if (reset) begin
            w_stall = 1'b0;
        end
    end

    assign mem.mem_req   = r_mem_req;
    assign mem.mem_we    = r_mem_we;
    assign mem.mem_addr  = r_mem_addr;
    assign mem.mem_wdata = r_mem_wdata;
    assign rdata_out     = r_rdata_out;
    assign timeout_err   = r_timeout_err;
    assign stall         = w_stall;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: directed scenarios followed by
// randomized transactions checked against a transaction-level reference model.
module tb_dmem_access_ctrl;

    localparam int unsigned TMO = 16;

    logic        clk;
    logic        reset;
    logic        MemRead_MEM;
    logic        MemWrite_MEM;
    logic [31:0] ALUresult_MEM;
    logic [31:0] data2_MEM;
    logic [31:0] rdata_out;
    logic        stall;
    logic        timeout_err;

    dmem_access_ctrl_if bus ();

    dmem_access_ctrl #(
        .TIMEOUT_CYCLES (TMO),
        .CNT_W          (5)
    ) u_dut (
        .clk           (clk),
        .reset         (reset),
        .MemRead_MEM   (MemRead_MEM),
        .MemWrite_MEM  (MemWrite_MEM),
        .ALUresult_MEM (ALUresult_MEM),
        .data2_MEM     (data2_MEM),
        .mem           (bus),
        .rdata_out     (rdata_out),
        .stall         (stall),
        .timeout_err   (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference model state: architectural results visible after each access.
    logic [31:0] exp_rdata;
    logic        exp_err;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Cycles with no access pending: random ready/rdata must be ignored.
    task automatic idle_cycles(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(negedge clk);
            MemRead_MEM   = 1'b0;
            MemWrite_MEM  = 1'b0;
            ALUresult_MEM = $urandom;
            data2_MEM     = $urandom;
            bus.mem_ready = 1'($urandom_range(0, 1));
            bus.mem_rdata = $urandom;
            #1;
            check_val("idle_stall", stall, 0);
            check_val("idle_req", bus.mem_req, 0);
            check_val("idle_rdata", rdata_out, exp_rdata);
            check_val("idle_err", timeout_err, exp_err);
        end
    endtask

    // One complete access; wait_n = cycles memory holds ready low before
    // asserting it. wait_n >= TMO means the memory never answers in time.
    task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wdat, input int unsigned wait_n);
        int unsigned busy_len;
        int unsigned stalls;
        int unsigned reqs;
        bit          tmo;
        logic [31:0] rv;
        tmo      = (wait_n >= TMO);
        busy_len = tmo ? TMO : wait_n + 1;
        stalls   = 0;
        reqs     = 0;
        rv       = '0;

        // IDLE detect cycle
        @(negedge clk);
        MemRead_MEM   = rd;
        MemWrite_MEM  = wr;
        ALUresult_MEM = addr;
        data2_MEM     = wdat;
        bus.mem_ready = 1'($urandom_range(0, 1));
        bus.mem_rdata = $urandom;
        #1;
        check_val("detect_req", bus.mem_req, 0);
        if (stall) stalls++;

        // BUSY cycles
        for (int unsigned k = 0; k < busy_len; k++) begin
            @(negedge clk);
            bus.mem_ready = (!tmo && k == wait_n);
            bus.mem_rdata = $urandom;
            rv            = bus.mem_rdata;
            #1;
            if (bus.mem_req) reqs++;
            if (stall) stalls++;
            check_val("busy_addr", bus.mem_addr, addr);
            check_val("busy_we", bus.mem_we, wr);
            if (wr) check_val("busy_wdata", bus.mem_wdata, wdat);
        end

        // Outcome of the access per the rules
        if (!wr) exp_rdata = tmo ? 32'h0 : rv;
        if (tmo) exp_err = 1'b1;

        // DONE cycle: MEM inputs are stale and must be ignored
        @(negedge clk);
        MemRead_MEM   = 1'($urandom_range(0, 1));
        MemWrite_MEM  = 1'($urandom_range(0, 1));
        ALUresult_MEM = $urandom;
        data2_MEM     = $urandom;
        bus.mem_ready = 1'($urandom_range(0, 1));
        bus.mem_rdata = $urandom;
        #1;
        check_val("done_stall", stall, 0);
        check_val("done_req", bus.mem_req, 0);
        check_val("done_rdata", rdata_out, exp_rdata);
        check_val("done_err", timeout_err, exp_err);
        check_val("stall_cycles", stalls, tmo ? TMO + 1 : wait_n + 2);
        check_val("req_cycles", reqs, busy_len);
    endtask

    initial begin
        reset         = 1'b1;
        MemRead_MEM   = 1'b1;
        MemWrite_MEM  = 1'b0;
        ALUresult_MEM = '0;
        data2_MEM     = '0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        exp_rdata     = '0;
        exp_err       = 1'b0;

        // Reset held two cycles with a load pending
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_req", bus.mem_req, 0);
        check_val("rst_stall", stall, 0);
        check_val("rst_rdata", rdata_out, 0);
        check_val("rst_err", timeout_err, 0);
        check_val("rst_addr", bus.mem_addr, 0);
        reset = 1'b0;
        #1;
        check_val("post_rst_stall", stall, 1);
        MemRead_MEM = 1'b0;
        idle_cycles(2);

        // Zero-wait load
        do_access(1'b1, 1'b0, 32'h0000_0040, 32'h0, 0);
        // Store with 3 wait cycles
        do_access(1'b0, 1'b1, 32'h0000_0100, 32'h1234_5678, 3);
        // Success exactly at the timeout boundary
        do_access(1'b1, 1'b0, 32'h0000_0200, 32'h0, TMO - 1);
        // Timeout on a load, then a normal load with the flag sticky
        do_access(1'b1, 1'b0, 32'h0000_0300, 32'h0, TMO + 4);
        do_access(1'b1, 1'b0, 32'h0000_0304, 32'h0, 1);
        // Simultaneous read+write (store wins), back-to-back with a load
        do_access(1'b1, 1'b1, 32'h0000_0400, 32'hA5A5_5A5A, 0);
        do_access(1'b1, 1'b0, 32'h0000_0404, 32'h0, 2);
        idle_cycles(1);

        // Reset in the second BUSY cycle abandons the access
        @(negedge clk);
        MemRead_MEM   = 1'b1;
        ALUresult_MEM = 32'h0000_0500;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset       = 1'b1;
        MemRead_MEM = 1'b0;
        @(negedge clk);
        reset     = 1'b0;
        exp_rdata = '0;
        exp_err   = 1'b0;
        #1;
        check_val("midrst_req", bus.mem_req, 0);
        check_val("midrst_stall", stall, 0);
        check_val("midrst_addr", bus.mem_addr, 0);
        check_val("midrst_rdata", rdata_out, 0);
        check_val("midrst_err", timeout_err, 0);
        idle_cycles(1);

        // Randomized transactions
        for (int unsigned t = 0; t < 60; t++) begin
            logic        rd;
            logic        wr;
            int unsigned w;
            int unsigned sel;
            sel = $urandom_range(0, 9);
            rd  = 1'($urandom_range(0, 1));
            wr  = rd ? 1'($urandom_range(0, 3) == 0) : 1'b1;
            if (sel < 7)       w = $urandom_range(0, 5);
            else if (sel == 7) w = TMO - 1;
            else if (sel == 8) w = TMO;
            else               w = $urandom_range(6, TMO + 6);
            do_access(rd, wr, $urandom, $urandom, w);
            if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 3));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
